// File: rtl/cache_fill_fsm_pkg.sv
// rtl/cache_fill_fsm_pkg.sv - shared constants and state encoding for the cache fill block
package cache_fill_fsm_pkg;

    localparam int DFLT_BLOCK_WORDS = 8;
    localparam int DFLT_ADDR_W      = 16;
    localparam int WORD_BYTES       = 2;
    localparam int OFFSET_BITS      = $clog2(DFLT_BLOCK_WORDS * WORD_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    function automatic int offset_bits(input int block_words);
        return $clog2(block_words * WORD_BYTES);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// rtl/cache_fill_fsm_fill_counter.sv - resettable up-counter with enable and terminal-count flag
module cache_fill_fsm_fill_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_term_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign at_term_o = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss handler: stalls the pipeline and streams one block from memory
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int BLOCK_WORDS = DFLT_BLOCK_WORDS,
    parameter int ADDR_W      = DFLT_ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic                           memory_valid,
    input  logic [15:0]                    memory_data_in,
    output logic                           fsm_busy,
    output logic                           mem_read_en,
    output logic [ADDR_W-1:0]              memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] cache_word,
    output logic [15:0]                    cache_data,
    output logic                           write_tag_array
);

    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam int OFF_W  = offset_bits(BLOCK_WORDS);
    localparam int BYTE_SHIFT = $clog2(WORD_BYTES);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    fill_state_e state_q;
    fill_state_e state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] word_q;

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              issue_done;
    logic              recv_last;

    logic              start;
    logic              rd;
    logic              wr;
    logic              last;
    logic [ADDR_W-1:0] issue_addr;

    assign start      = (state_q == IDLE) && miss_detected;
    assign rd         = (state_q == FILL) && !issue_done;
    assign wr         = (state_q == FILL) && memory_valid;
    assign last       = wr && recv_last;
    assign issue_addr = base_q + (ADDR_W'(issue_cnt) << BYTE_SHIFT);

    cache_fill_fsm_fill_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (BLOCK_WORDS)
    ) issue_cnt_u (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start),
        .en_i      (rd),
        .count_o   (issue_cnt),
        .at_term_o (issue_done)
    );

    cache_fill_fsm_fill_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (BLOCK_WORDS - 1)
    ) recv_cnt_u (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start),
        .en_i      (wr),
        .count_o   (recv_cnt),
        .at_term_o (recv_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_detected) state_d = FILL;
            FILL:    if (last)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address and word offset are held between strobes so the buses stay quiet when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            addr_q <= '0;
            word_q <= '0;
        end else begin
            if (start) base_q <= miss_address & ~OFF_MASK;
            if (rd)    addr_q <= issue_addr;
            if (wr)    word_q <= recv_cnt[WORD_W-1:0];
        end
    end

    always_comb begin
        fsm_busy         = 1'b0;
        mem_read_en      = rd;
        memory_address   = rd ? issue_addr : addr_q;
        write_data_array = wr;
        cache_word       = wr ? recv_cnt[WORD_W-1:0] : word_q;
        cache_data       = wr ? memory_data_in : 16'h0000;
        write_tag_array  = last;
        case (state_q)
            IDLE:    fsm_busy = miss_detected;
            FILL:    fsm_busy = 1'b1;
            default: fsm_busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_valid;
    logic [15:0] memory_data_in;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  cache_word;
    logic [15:0] cache_data;
    logic        write_tag_array;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_valid     (memory_valid),
        .memory_data_in   (memory_data_in),
        .fsm_busy         (fsm_busy),
        .mem_read_en      (mem_read_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .cache_word       (cache_word),
        .cache_data       (cache_data),
        .write_tag_array  (write_tag_array)
    );

    // {busy, read_en, address, data_write, word, data, tag_write}
    logic [38:0] obs;
    assign obs = {fsm_busy, mem_read_en, memory_address, write_data_array,
                  cache_word, cache_data, write_tag_array};

    function automatic logic [38:0] pk(input logic b, input logic r, input logic [15:0] a,
                                       input logic w, input logic [2:0] k, input logic [15:0] d,
                                       input logic t);
        return {b, r, a, w, k, d, t};
    endfunction

    // Address is only meaningful with a read strobe, word/data only with a write strobe.
    function automatic logic [38:0] mk(input logic r, input logic w);
        return {1'b1, 1'b1, {16{r}}, 1'b1, {3{w}}, {16{w}}, 1'b1};
    endfunction

    task automatic drive(input logic m, input logic [15:0] ma, input logic v, input logic [15:0] vd);
        miss_detected  = m;
        miss_address   = ma;
        memory_valid   = v;
        memory_data_in = vd;
    endtask

    task automatic test_reset;
        logic [38:0] e;
        rst = 1'b1;
        drive(1'b1, 16'h5555, 1'b1, 16'h1111);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 16'h5555, 1'b0, 16'h0000);
        @(negedge clk);
        e = pk(1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required %h", obs, e);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0000, 1'b1, 16'h7777);
        @(negedge clk);
        e = pk(1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
        n_cmp++;
        if ((obs & mk(1'b0, 1'b0)) !== (e & mk(1'b0, 1'b0))) begin
            n_err++;
            $display("FAIL idle_ignores_valid: got %h required %h", obs, e);
        end
    endtask

    task automatic test_basic_fill;
        logic b, r, w, t;
        logic [15:0] a, d;
        logic [2:0] k;
        logic [38:0] e, m;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            w = (c >= 5 && c <= 12);
            k = 3'(c - 5);
            d = 16'hA000 + 16'(c - 5);
            drive(c == 0, 16'h1234, w, w ? d : 16'h0000);
            @(negedge clk);
            b = (c <= 12);
            r = (c >= 1 && c <= 8);
            a = 16'h1230 + 16'(2 * (c - 1));
            t = (c == 12);
            e = pk(b, r, a, w, k, d, t);
            m = mk(r, w);
            n_cmp++;
            if ((obs & m) !== (e & m)) begin
                n_err++;
                $display("FAIL basic_fill c%0d: got %h required %h", c, obs & m, e & m);
            end
        end
    endtask

    task automatic test_variable_latency;
        logic b, r, w, t;
        logic [15:0] a, d;
        logic [38:0] e, m;
        int idx = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            w = (c >= 3 && c <= 6) || (c >= 9 && c <= 11) || (c == 13);
            d = 16'hB000 + 16'(idx);
            drive(c == 0, 16'h2468, w, w ? d : 16'h0000);
            @(negedge clk);
            b = (c <= 13);
            r = (c >= 1 && c <= 8);
            a = 16'h2460 + 16'(2 * (c - 1));
            t = (c == 13);
            e = pk(b, r, a, w, 3'(idx), d, t);
            m = mk(r, w);
            n_cmp++;
            if ((obs & m) !== (e & m)) begin
                n_err++;
                $display("FAIL variable_latency c%0d: got %h required %h", c, obs & m, e & m);
            end
            if (w) idx++;
        end
    endtask

    task automatic test_miss_during_fill;
        logic b, r, w, t, mi;
        logic [15:0] a, d, ma;
        logic [2:0] k;
        logic [38:0] e, m;
        for (int c = 0; c < 23; c++) begin
            @(posedge clk);
            #1;
            mi = (c <= 11);
            ma = (c == 0) ? 16'h0100 : 16'h4000;
            if (c >= 3 && c <= 10) begin
                w = 1'b1; k = 3'(c - 3);  d = 16'hC000 + 16'(c - 3);
            end else if (c >= 14 && c <= 21) begin
                w = 1'b1; k = 3'(c - 14); d = 16'hC100 + 16'(c - 14);
            end else begin
                w = 1'b0; k = 3'd0; d = 16'h0000;
            end
            drive(mi, ma, w, d);
            @(negedge clk);
            b = (c <= 21);
            if (c >= 1 && c <= 8) begin
                r = 1'b1; a = 16'h0100 + 16'(2 * (c - 1));
            end else if (c >= 12 && c <= 19) begin
                r = 1'b1; a = 16'h4000 + 16'(2 * (c - 12));
            end else begin
                r = 1'b0; a = 16'h0000;
            end
            t = (c == 10) || (c == 21);
            e = pk(b, r, a, w, k, d, t);
            m = mk(r, w);
            n_cmp++;
            if ((obs & m) !== (e & m)) begin
                n_err++;
                $display("FAIL miss_during_fill c%0d: got %h required %h", c, obs & m, e & m);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic b, r, w, t, mi;
        logic [15:0] a, d, ma;
        logic [2:0] k;
        logic [38:0] e, m;
        for (int c = 0; c < 21; c++) begin
            @(posedge clk);
            #1;
            mi = (c == 0) || (c == 10);
            ma = (c == 0) ? 16'h0020 : 16'h0010;
            if (c >= 2 && c <= 9) begin
                w = 1'b1; k = 3'(c - 2);  d = 16'hE000 + 16'(c - 2);
            end else if (c >= 12 && c <= 19) begin
                w = 1'b1; k = 3'(c - 12); d = 16'hE100 + 16'(c - 12);
            end else begin
                w = 1'b0; k = 3'd0; d = 16'h0000;
            end
            drive(mi, ma, w, d);
            @(negedge clk);
            b = (c <= 19);
            if (c >= 1 && c <= 8) begin
                r = 1'b1; a = 16'h0020 + 16'(2 * (c - 1));
            end else if (c >= 11 && c <= 18) begin
                r = 1'b1; a = 16'h0010 + 16'(2 * (c - 11));
            end else begin
                r = 1'b0; a = 16'h0000;
            end
            t = (c == 9) || (c == 19);
            e = pk(b, r, a, w, k, d, t);
            m = mk(r, w);
            n_cmp++;
            if ((obs & m) !== (e & m)) begin
                n_err++;
                $display("FAIL back_to_back c%0d: got %h required %h", c, obs & m, e & m);
            end
        end
    endtask

    task automatic test_reset_mid_fill;
        logic b, r, w, t, mi;
        logic [15:0] a, d, ma;
        logic [2:0] k;
        logic [38:0] e, m;
        for (int c = 0; c < 21; c++) begin
            @(posedge clk);
            #1;
            rst = (c == 5);
            mi = (c == 0) || (c == 10);
            ma = (c == 0) ? 16'h3000 : 16'h3456;
            if (c >= 2 && c <= 4) begin
                w = 1'b1; k = 3'(c - 2);  d = 16'hD000 + 16'(c - 2);
            end else if (c >= 7 && c <= 9) begin
                w = 1'b1; k = 3'd0;       d = 16'hDEAD;
            end else if (c >= 12 && c <= 19) begin
                w = 1'b1; k = 3'(c - 12); d = 16'hD100 + 16'(c - 12);
            end else begin
                w = 1'b0; k = 3'd0; d = 16'h0000;
            end
            drive(mi, ma, w, d);
            @(negedge clk);
            b = (c <= 5) || (c >= 10 && c <= 19);
            if (c >= 1 && c <= 5) begin
                r = 1'b1; a = 16'h3000 + 16'(2 * (c - 1));
            end else if (c >= 11 && c <= 18) begin
                r = 1'b1; a = 16'h3450 + 16'(2 * (c - 11));
            end else begin
                r = 1'b0; a = 16'h0000;
            end
            t = (c == 19);
            if (c >= 7 && c <= 9) w = 1'b0;
            e = pk(b, r, a, w, k, (c == 6) ? 16'h0000 : d, t);
            m = (c == 6) ? {39{1'b1}} : mk(r, w);
            n_cmp++;
            if ((obs & m) !== (e & m)) begin
                n_err++;
                $display("FAIL reset_mid_fill c%0d: got %h required %h", c, obs & m, e & m);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap_boundary;
        logic b, r, w, t;
        logic [15:0] a, d;
        logic [2:0] k;
        logic [38:0] e, m;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk);
            #1;
            w = (c >= 4 && c <= 11);
            k = 3'(c - 4);
            d = 16'hF000 + 16'(c - 4);
            drive(c == 0, 16'hFFFE, w, w ? d : 16'h0000);
            @(negedge clk);
            b = (c <= 11);
            r = (c >= 1 && c <= 8);
            a = 16'hFFF0 + 16'(2 * (c - 1));
            t = (c == 11);
            e = pk(b, r, a, w, k, d, t);
            m = mk(r, w);
            n_cmp++;
            if ((obs & m) !== (e & m)) begin
                n_err++;
                $display("FAIL wrap_boundary c%0d: got %h required %h", c, obs & m, e & m);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 16'h0000);
        test_reset();
        test_basic_fill();
        test_variable_latency();
        test_miss_during_fill();
        test_back_to_back();
        test_reset_mid_fill();
        test_wrap_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling responder between the pipelined CPU's cache lookup and a multi-cycle main memory.
- On a cache miss it stalls the requesting pipeline stage.
- It streams one full 8-word block from main memory and writes each returned word into the cache data array.
- It writes the tag on the final word, then releases the stall.
- One instance per cache (I-cache, D-cache). The memory arbiter between the two instances is out of scope.

Parameters:
- BLOCK_WORDS, 8: words per cache block. Must be a power of two.
- ADDR_W, 16: byte-address width. Words are 16-bit, so a block is 2*BLOCK_WORDS bytes.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- miss_detected  input  1  cache lookup missed this cycle
- miss_address  input  ADDR_W  byte address of the missing access
- memory_valid  input  1  memory_data_in holds a returned word this cycle
- memory_data_in  input  16  word returned from main memory
- fsm_busy  output  1  stall request to the pipeline
- mem_read_en  output  1  issue a read of memory_address this cycle
- memory_address  output  ADDR_W  byte address sent to main memory
- write_data_array  output  1  write cache_data into word cache_word of the line
- cache_word  output  log2(BLOCK_WORDS)  word offset for the data-array write
- cache_data  output  16  word to write (equals memory_data_in)
- write_tag_array  output  1  one-cycle pulse: write tag and valid for the block

Behaviour:
- Reset: on rst high at a rising edge, the block enters state IDLE and clears issue_cnt, recv_cnt and base.
  - All outputs are 0 in the following cycle.
  - rst overrides every other input, including a reset mid-fill.
- Words returned after a reset are ignored, because the block is in IDLE. Main memory shares the same rst, so no stale word is returned after a new fill starts.
- State IDLE:
  - fsm_busy = miss_detected (combinational), so the pipeline stalls in the miss cycle itself.
  - On miss_detected: base <= miss_address with the low log2(2*BLOCK_WORDS) bits cleared (0x...0 for 8 words); issue_cnt <= 0; recv_cnt <= 0; next state FILL.
  - memory_valid is ignored in IDLE.
- State FILL:
  - fsm_busy = 1.
  - Issue side: mem_read_en = (issue_cnt < BLOCK_WORDS).
    - memory_address = base + 2*issue_cnt, using ADDR_W-bit arithmetic. No carry into the tag is possible, because base is block-aligned.
    - issue_cnt increments each cycle while mem_read_en is high. Exactly BLOCK_WORDS reads are issued, in consecutive cycles starting the cycle after the miss.
  - Receive side: each cycle with memory_valid high:
    - write_data_array = 1, cache_word = recv_cnt, cache_data = memory_data_in.
    - recv_cnt increments.
    - Words are assumed to return in issue order. The number of latency cycles is not assumed; the block only counts memory_valid.
  - When memory_valid is high and recv_cnt == BLOCK_WORDS-1: write_tag_array = 1 in the same cycle as the last data write, and next state is IDLE.
- Outside these conditions, mem_read_en, write_data_array and write_tag_array are 0. memory_address and cache_word hold their last value (don't-care for consumers).
- Simultaneous events:
  - miss_detected during FILL, including the completion cycle, is ignored. The stalled stage re-presents the miss if it still misses after the tag write.
  - A miss in the first IDLE cycle after completion is accepted normally (back-to-back fills).
- Issue and receive may overlap: the last reads can still be issuing while the first words return.
- Latency with 4-cycle memory (data valid 4 cycles after issue), miss in cycle T:
  - reads issued in T+1..T+8
  - data written in T+5..T+12
  - write_tag_array in T+12
  - fsm_busy low from T+13

Decomposition:
- Shared cache package holds:
  - state encoding typedef {IDLE, FILL}
  - constants BLOCK_WORDS, WORD_BYTES=2, OFFSET_BITS = log2(BLOCK_WORDS*WORD_BYTES)
- Natural sub-module: fill_counter, a resettable up-counter with enable and terminal-count flag. It is instantiated twice, as issue_cnt and recv_cnt.

Test Plan:
- Basic fill: miss_address=0x1234, memory model with 4-cycle latency returning 0xA000+i → addresses 0x1230..0x123E issued in T+1..T+8; words 0..7 written as 0xA000..0xA007; write_tag_array pulses at T+12; fsm_busy falls at T+13.
- Variable latency: memory_valid with gaps (e.g. 2 idle cycles between words 3 and 4) → still exactly 8 data writes, offsets in order, and the tag pulse only on the 8th valid.
- Miss during fill: assert miss_detected with miss_address=0x4000 throughout FILL → no restart, and no 0x4000 address issued until after the tag write; then a fresh fill of 0x4000..0x400E.
- Back-to-back: second miss (0x0010) in the cycle after fsm_busy falls → accepted immediately; issue starts the next cycle at 0x0010.
- Reset mid-fill: rst high after the 3rd received word → next cycle fsm_busy=0 and all strobes 0; late memory_valid pulses cause no writes; a subsequent miss restarts from word 0.
- Wrap/boundary: miss_address=0xFFFE → base 0xFFF0; addresses 0xFFF0..0xFFFE issued; no address wrap past 0xFFFE.
